vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/29, in lines.
REQ-006 SHALL have parameters H_POL and V_POL, default 0 each, sync asserted level (0 = active-low).
REQ-007 SHALL have parameter CW, default 11, width of the counter and coordinate outputs.
REQ-008 SHALL have port dclk, input, 1 bit, pixel/system clock.
REQ-009 SHALL have port clr, input, 1 bit, reset, asynchronous, active-high.
REQ-010 SHALL have port pix_ce, input, 1 bit, pixel-advance enable.
REQ-011 SHALL have ports hsync and vsync, output, 1 bit each, registered sync outputs.
REQ-012 SHALL have ports x_pixel and y_pixel, output, CW bits each, active-area coordinates.
REQ-013 SHALL have port vid_enable, output, 1 bit, high inside the active area.
REQ-014 SHALL have ports line_start and frame_start, output, 1 bit each, one-cycle strobes.
REQ-015 SHALL have port frame_count, output, 16 bits, completed-frame counter (see Configuration).

Function
REQ-016 SHALL derive H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP; order within a line/frame is sync, back porch, active, front porch.
REQ-017 SHALL advance internal hc/vc only on dclk edges with pix_ce=1; with pix_ce=0, every register holds, except that line_start and frame_start are forced to 0.
REQ-018 SHALL count hc 0..H_TOTAL-1; at H_TOTAL-1 it wraps to 0 and vc increments; at vc=V_TOTAL-1 with hc=H_TOTAL-1, both wrap to 0 in the same cycle.
REQ-019 SHALL define active as hc in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vc in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1], inclusive at both ends, so exactly H_ACTIVE x V_ACTIVE pixels per frame.
REQ-020 SHALL assert sync at level H_POL while hc<H_SYNC and level V_POL while vc<V_SYNC; otherwise sync is the inverse level.
REQ-021 SHALL register all outputs with 1 pix_ce-qualified cycle of latency from the hc/vc values that produce them; all outputs stay mutually aligned.
REQ-022 SHALL drive x_pixel = hc-(H_SYNC+H_BP) and y_pixel = vc-(V_SYNC+V_BP) when active, and 0 for both otherwise.
REQ-023 SHALL pulse line_start for one dclk cycle when the registered hc=0, and frame_start when hc=0 and vc=0 together (frame_start implies line_start).
REQ-024 SHALL require CW to be wide enough for H_TOTAL-1 and V_TOTAL-1; the internal counters are CW bits wide.

Reset
REQ-025 SHALL, while clr=1, asynchronously force hc=0, vc=0, x_pixel=0, y_pixel=0, vid_enable=0, line_start=0, frame_start=0 and frame_count=0, with hsync=~H_POL and vsync=~V_POL.
REQ-026 SHALL, on clr deassertion, emit the first frame_start on the first pix_ce=1 edge, then run normally.
REQ-027 SHALL abandon a frame in progress on a mid-frame clr and restart it from hc=vc=0, with no partial-frame increment of frame_count.

Configuration
REQ-028 SHALL, with macro VGA_TIMING_FRAME_CNT_EN defined, increment frame_count by 1 (wrapping at 65535 to 0) on each hc/vc wrap to 0,0, updating in the same cycle as frame_start.
REQ-029 SHALL, without VGA_TIMING_FRAME_CNT_EN, keep the frame_count port and tie it to constant 0, with no counter logic.

Verification
REQ-030 SHALL cover defaults with pix_ce=1: hsync low for 96 cycles per 800-cycle line, vsync low for 2 lines per 521-line frame, and vid_enable high for exactly 307200 cycles per frame.
REQ-031 SHALL cover the first active pixel: registered hc=144, vc=31 -> x_pixel=0, y_pixel=0, vid_enable=1; at hc=783 -> x_pixel=639; at hc=784 -> vid_enable=0, x_pixel=0.
REQ-032 SHALL cover small parameters (H 4/1/1/1, V 3/1/1/1, H_POL=1) over two frames: hsync high for 1 of 7 cycles, frame_start period 42 cycles, and x sequence 0,1,2,3 per active line.
REQ-033 SHALL cover pix_ce toggling 1,0,1,0: outputs change only after pix_ce=1 edges, strobes are never held for two cycles, and frame period is 2x the pix_ce=1 case.
REQ-034 SHALL cover clr pulsed at hc=300, vc=200: all outputs go to reset values without a dclk edge, and the next frame_start comes one pix_ce edge after release.
REQ-035 SHALL cover VGA_TIMING_FRAME_CNT_EN: after 3 full frames, frame_count=3 (it stays 0 without the macro), and with a forced counter at 65535 the next frame wraps it to 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sync, active-area coordinates and frame/line strobes.
// Optional completed-frame counter is enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 29,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CW       = 11
) (
    input  logic          dclk,
    input  logic          clr,
    input  logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] x_pixel,
    output logic [CW-1:0] y_pixel,
    output logic          vid_enable,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // CW must hold H_TOTAL-1 and V_TOTAL-1; the casts below truncate otherwise.
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
    localparam logic [CW-1:0] H_A0     = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_A1     = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CW-1:0] V_A0     = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_A1     = CW'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [CW-1:0] x_pixel_q, x_pixel_d;
    logic [CW-1:0] y_pixel_q, y_pixel_d;
    logic          vid_enable_q, vid_enable_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          h_act, v_act;

    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        x_pixel_d     = x_pixel_q;
        y_pixel_d     = y_pixel_q;
        vid_enable_d  = vid_enable_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_act         = (hc_q >= H_A0) && (hc_q <= H_A1);
        v_act         = (vc_q >= V_A0) && (vc_q <= V_A1);

        if (pix_ce) begin
            // Outputs reflect the counter values present before this advance.
            hsync_d       = (hc_q < H_SYNC_C) ? H_POL : ~H_POL;
            vsync_d       = (vc_q < V_SYNC_C) ? V_POL : ~V_POL;
            vid_enable_d  = h_act && v_act;
            x_pixel_d     = (h_act && v_act) ? (hc_q - H_A0) : '0;
            y_pixel_d     = (h_act && v_act) ? (vc_q - V_A0) : '0;
            line_start_d  = (hc_q == '0);
            frame_start_d = (hc_q == '0) && (vc_q == '0);

            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hc_q          <= '0;
            vc_q          <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            x_pixel_q     <= '0;
            y_pixel_q     <= '0;
            vid_enable_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            x_pixel_q     <= x_pixel_d;
            y_pixel_q     <= y_pixel_d;
            vid_enable_q  <= vid_enable_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign x_pixel     = x_pixel_q;
    assign y_pixel     = y_pixel_q;
    assign vid_enable  = vid_enable_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;
    logic        armed_q, armed_d;

    // The first frame_start after reset begins a frame rather than completing one.
    always_comb begin
        armed_d       = armed_q | pix_ce;
        frame_count_d = frame_count_q;
        if (pix_ce && armed_q && (hc_q == '0) && (vc_q == '0))
            frame_count_d = frame_count_q + 16'd1;
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            frame_count_q <= '0;
            armed_q       <= 1'b0;
        end else begin
            frame_count_q <= frame_count_d;
            armed_q       <= armed_d;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-enable bench for vga_timing_gen: three instances checked every cycle against an
// arithmetic raster model, plus literal checks on known raster positions.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    typedef struct {
        int hs, vs, x, y, de, ls, fs, fc;
    } exp_t;

    logic dclk = 1'b0;
    always #5 dclk = ~dclk;

    logic clr0 = 1'b1, clr1 = 1'b1, clr2 = 1'b1;
    logic ce0 = 1'b1, ce1 = 1'b1, ce2 = 1'b0;

    logic        hs0, vs0, de0, ls0, fs0;
    logic [10:0] x0, y0;
    logic [15:0] fc0;
    logic        hs1, vs1, de1, ls1, fs1;
    logic [3:0]  x1, y1;
    logic [15:0] fc1;
    logic        hs2, vs2, de2, ls2, fs2;
    logic [5:0]  x2, y2;
    logic [15:0] fc2;

    vga_timing_gen d0 (
        .dclk(dclk), .clr(clr0), .pix_ce(ce0), .hsync(hs0), .vsync(vs0),
        .x_pixel(x0), .y_pixel(y0), .vid_enable(de0), .line_start(ls0),
        .frame_start(fs0), .frame_count(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .CW(4)
    ) d1 (
        .dclk(dclk), .clr(clr1), .pix_ce(ce1), .hsync(hs1), .vsync(vs1),
        .x_pixel(x1), .y_pixel(y1), .vid_enable(de1), .line_start(ls1),
        .frame_start(fs1), .frame_count(fc1)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b1), .CW(6)
    ) d2 (
        .dclk(dclk), .clr(clr2), .pix_ce(ce2), .hsync(hs2), .vsync(vs2),
        .x_pixel(x2), .y_pixel(y2), .vid_enable(de2), .line_start(ls2),
        .frame_start(fs2), .frame_count(fc2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string t, input exp_t e, input logic hs, input logic vs,
                           input int x, input int y, input logic de, input logic ls,
                           input logic fs, input int fc);
        chk({t, "_hsync"}, hs, e.hs);
        chk({t, "_vsync"}, vs, e.vs);
        chk({t, "_x"}, x, e.x);
        chk({t, "_y"}, y, e.y);
        chk({t, "_de"}, de, e.de);
        chk({t, "_line_start"}, ls, e.ls);
        chk({t, "_frame_start"}, fs, e.fs);
        chk({t, "_frame_count"}, fc, e.fc);
    endtask

    // k = number of enabled edges since reset release; edge k shows raster position k-1.
    function automatic exp_t model(input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                   input bit hp, vp, input longint k, input bit lc);
        exp_t e;
        int ht, vt, hc, vc;
        longint p;
        bit act;
        ht = hsw + hb + ha + hf;
        vt = vsw + vb + va + vf;
        e.hs = int'(!hp); e.vs = int'(!vp);
        e.x = 0; e.y = 0; e.de = 0; e.ls = 0; e.fs = 0; e.fc = 0;
        if (k > 0) begin
            p   = (k - 1) % (ht * vt);
            hc  = int'(p % ht);
            vc  = int'(p / ht);
            act = (hc >= hsw + hb) && (hc < hsw + hb + ha) &&
                  (vc >= vsw + vb) && (vc < vsw + vb + va);
            e.hs = (hc < hsw) ? int'(hp) : int'(!hp);
            e.vs = (vc < vsw) ? int'(vp) : int'(!vp);
            e.de = int'(act);
            e.x  = act ? hc - (hsw + hb) : 0;
            e.y  = act ? vc - (vsw + vb) : 0;
            e.ls = int'(lc && hc == 0);
            e.fs = int'(lc && hc == 0 && vc == 0);
            e.fc = FC_EN ? int'(((k - 1) / (ht * vt)) % 65536) : 0;
        end
        return e;
    endfunction

    longint k0 = 0, k1 = 0, k2 = 0;
    bit lc0 = 1'b0, lc1 = 1'b0, lc2 = 1'b0;

    always @(posedge dclk or posedge clr0)
        if (clr0) k0 <= 0; else begin if (ce0) k0 <= k0 + 1; lc0 <= ce0; end
    always @(posedge dclk or posedge clr1)
        if (clr1) k1 <= 0; else begin if (ce1) k1 <= k1 + 1; lc1 <= ce1; end
    always @(posedge dclk or posedge clr2)
        if (clr2) k2 <= 0; else begin if (ce2) k2 <= k2 + 1; lc2 <= ce2; end

    exp_t e0, e1, e2;
    int   cyc_cnt = 0;
    int   hs0_low = 0, de0_cnt = 0, vs0_low = 0, hs1_high = 0;
    int   last_fs1 = -1, last_fs2 = -1;
    bit   prev_ls2 = 1'b0, prev_fs2 = 1'b0;
    int   xq1[$];

    always @(negedge dclk) begin
        cyc_cnt++;
        e0 = model(640, 16, 96, 48, 480, 10, 2, 29, 1'b0, 1'b0, k0, lc0);
        e1 = model(4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b0, k1, lc1);
        e2 = model(8, 2, 3, 2, 5, 1, 2, 2, 1'b0, 1'b1, k2, lc2);
        chk_all("d0", e0, hs0, vs0, int'(x0), int'(y0), de0, ls0, fs0, int'(fc0));
        chk_all("d1", e1, hs1, vs1, int'(x1), int'(y1), de1, ls1, fs1, int'(fc1));
        chk_all("d2", e2, hs2, vs2, int'(x2), int'(y2), de2, ls2, fs2, int'(fc2));

        // Default timing: first line / first 32 lines, and the first active pixel row.
        if (k0 >= 1 && k0 <= 800 && hs0 == 1'b0) hs0_low++;
        if (k0 >= 1 && k0 <= 25600) begin
            if (de0) de0_cnt++;
            if (vs0 == 1'b0) vs0_low++;
        end
        if (k0 == 801) chk("d0_hsync_low_per_line", hs0_low, 96);
        if (k0 == 25601) begin
            chk("d0_active_in_32_lines", de0_cnt, 640);
            chk("d0_vsync_low_cycles", vs0_low, 1600);
        end
        if (k0 == 24945) begin
            chk("d0_first_px_x", x0, 0);
            chk("d0_first_px_y", y0, 0);
            chk("d0_first_px_de", de0, 1);
        end
        if (k0 == 25584) chk("d0_last_px_x", x0, 639);
        if (k0 == 25585) begin
            chk("d0_after_last_de", de0, 0);
            chk("d0_after_last_x", x0, 0);
        end

        // Small raster: one frame with continuous enable.
        if (k1 >= 1 && k1 <= 42) begin
            if (hs1) hs1_high++;
            if (de1) xq1.push_back(int'(x1));
        end
        if (k1 == 43) begin
            chk("d1_hsync_high_per_frame", hs1_high, 6);
            chk("d1_active_count", xq1.size(), 12);
            foreach (xq1[i]) chk("d1_x_seq", xq1[i], i % 4);
        end
        if (fs1) begin
            if (last_fs1 >= 0 && cyc_cnt <= 100) chk("d1_frame_period", cyc_cnt - last_fs1, 42);
            last_fs1 = cyc_cnt;
        end

        // Medium raster: alternating enable doubles the frame period; strobes stay one cycle.
        if (fs2) begin
            if (last_fs2 >= 0 && cyc_cnt <= 650) chk("d2_frame_period_x2", cyc_cnt - last_fs2, 300);
            last_fs2 = cyc_cnt;
        end
        if (prev_ls2) chk("d2_line_start_hold", ls2, 0);
        if (prev_fs2) chk("d2_frame_start_hold", fs2, 0);
        prev_ls2 = ls2;
        prev_fs2 = fs2;
        if (k2 == 451) chk("d2_frame_count_after_3", fc2, FC_EN ? 3 : 0);
    end

    initial begin
        repeat (3) @(negedge dclk);
        #1;
        chk("d1_reset_hsync", hs1, 0);
        chk("d2_reset_vsync", vs2, 0);
        chk("d0_reset_hsync", hs0, 1);
        clr0 = 1'b0;
        clr1 = 1'b0;
        clr2 = 1'b0;
        for (int cyc = 0; cyc < 26000; cyc++) begin
            @(negedge dclk);
            #1;
            ce1 = (cyc < 100) ? 1'b1 : 1'($urandom_range(0, 1));
            if (cyc < 700) ce2 = (cyc % 2 == 0);
            else           ce2 = ($urandom_range(0, 3) != 0);
            if (cyc == 1500) begin
                clr2 = 1'b1;
                #1;
                chk("d2_clr_hsync", hs2, 1);
                chk("d2_clr_vsync", vs2, 0);
                chk("d2_clr_x", x2, 0);
                chk("d2_clr_y", y2, 0);
                chk("d2_clr_de", de2, 0);
                chk("d2_clr_ls", ls2, 0);
                chk("d2_clr_fs", fs2, 0);
                chk("d2_clr_fc", fc2, 0);
            end else if (cyc == 1501) begin
                clr2 = 1'b0;
                ce2  = 1'b1;
                @(posedge dclk);
                #1;
                chk("d2_restart_fs", fs2, 1);
                chk("d2_restart_ls", ls2, 1);
                chk("d2_restart_fc", fc2, 0);
            end
        end
        @(negedge dclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
